output_history_rotator: RTL and testbench

Captures each distinct value on the CPU result bus into a DEPTH-entry circular history and cycles the display output through the stored values, oldest to newest, holding each for DWELL_CYCLES clocks. It sits between the CPU result bus and the seven-segment/LED display driver. It generalises the two-value alternating output stage to N values, with configurable width, dwell, hold and clear.

---
 rtl/output_history_rotator.sv | 100 ++++++++++
 tb/tb_output_history_rotator.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/output_history_rotator.sv
// Keeps a DEPTH-entry circular history of distinct result-bus values and rotates the
// display through it, oldest to newest. Optional: OUTREAD_JUMP_NEW_EN jumps to a new push.
module output_history_rotator #(
  parameter  int DATA_W       = 32,
  parameter  int DEPTH        = 4,
  parameter  int DWELL_CYCLES = 200000000,
  localparam int CNT_W        = $clog2(DWELL_CYCLES + 1),
  localparam int IDX_W        = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] result_i,
  input  logic              hold_i,
  input  logic              clear_i,
  output logic [DATA_W-1:0] out_o,
  output logic [IDX_W-1:0]  out_idx_o,
  output logic [IDX_W:0]    count_o,
  output logic              new_o
);

  logic [DEPTH-1:0][DATA_W-1:0] mem;
  logic [DATA_W-1:0]            prev_q;
  logic [IDX_W-1:0]             wr_ptr, rd_idx, oldest, disp, rd_rot;
  logic [IDX_W:0]               count, count_next;
  logic [CNT_W-1:0]             dwell;
  logic                         push, jump, wrap;

  always_comb begin
    push       = (result_i != prev_q) && !clear_i;
    count_next = (push && count != (IDX_W+1)'(DEPTH)) ? count + 1'b1 : count;
    // DEPTH is a power of two, so truncating count gives (wr_ptr - count) mod DEPTH
    oldest     = wr_ptr - count[IDX_W-1:0];
    disp       = oldest + rd_idx;
    wrap       = (dwell == CNT_W'(DWELL_CYCLES - 1));
    rd_rot     = (({1'b0, rd_idx} + 1'b1) >= count_next) ? '0 : rd_idx + 1'b1;
`ifdef OUTREAD_JUMP_NEW_EN
    jump       = push;
`else
    jump       = 1'b0;
`endif
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= result_i;
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      prev_q <= '0;
      wr_ptr <= '0;
      count  <= '0;
      rd_idx <= '0;
      dwell  <= '0;
      new_o  <= 1'b0;
    end else begin
      prev_q <= result_i;
      new_o  <= push;
      if (clear_i) begin
        wr_ptr <= '0;
        count  <= '0;
        rd_idx <= '0;
        dwell  <= '0;
      end else begin
        if (push) begin
          wr_ptr <= wr_ptr + 1'b1;
          count  <= count_next;
        end
        // a jump overrides both hold and a coincident rotate
        if (jump) begin
          rd_idx <= count_next[IDX_W-1:0] - 1'b1;
          dwell  <= '0;
        end else if (count == '0) begin
          rd_idx <= '0;
          dwell  <= '0;
        end else if (!hold_i) begin
          if (wrap) begin
            dwell  <= '0;
            rd_idx <= rd_rot;
          end else begin
            dwell  <= dwell + 1'b1;
          end
        end
      end
    end
  end

  // display registers lag the history state by one cycle; clear blanks them immediately
  always_ff @(posedge clk) begin
    if (!rst || clear_i) begin
      out_o     <= '0;
      out_idx_o <= '0;
      count_o   <= '0;
    end else begin
      out_o     <= (count == '0) ? '0 : mem[disp];
      out_idx_o <= rd_idx;
      count_o   <= count;
    end
  end

endmodule

// File: tb/tb_output_history_rotator.sv
// Scoreboard bench for output_history_rotator (DEPTH=4, DWELL_CYCLES=4); expected
// display sequences are queued per scenario and popped one per clock.
module tb_output_history_rotator;
  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;
  localparam int DWELL  = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [DATA_W-1:0] result_i;
  logic              hold_i, clear_i;
  logic [DATA_W-1:0] out_o;
  logic [1:0]        out_idx_o;
  logic [2:0]        count_o;
  logic              new_o;

  int total = 0;
  int bad   = 0;
  logic [DATA_W-1:0] exp_v[$];
  logic [1:0]        exp_i[$];

  always #5 clk = ~clk;

  output_history_rotator #(.DATA_W(DATA_W), .DEPTH(DEPTH), .DWELL_CYCLES(DWELL)) dut (
    .clk(clk), .rst(rst), .result_i(result_i), .hold_i(hold_i), .clear_i(clear_i),
    .out_o(out_o), .out_idx_o(out_idx_o), .count_o(count_o), .new_o(new_o)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b0; result_i = '0; hold_i = 1'b0; clear_i = 1'b0;
    tick(); tick();
    rst = 1'b1;
  endtask

  task automatic push_run(input logic [DATA_W-1:0] v, input logic [1:0] idx, input int n);
    repeat (n) begin
      exp_v.push_back(v);
      exp_i.push_back(idx);
    end
  endtask

  task automatic test_reset();
    rst = 1'b0; result_i = 32'hDEAD; hold_i = 1'b0; clear_i = 1'b0;
    tick(); tick();
    total++; if (out_o !== '0)     begin bad++; $display("FAIL rst_out got %h want 0", out_o); end
    total++; if (count_o !== '0)   begin bad++; $display("FAIL rst_count got %0d want 0", count_o); end
    total++; if (out_idx_o !== '0) begin bad++; $display("FAIL rst_idx got %0d want 0", out_idx_o); end
    total++; if (new_o !== 1'b0)   begin bad++; $display("FAIL rst_new got %b want 0", new_o); end
    result_i = '0; rst = 1'b1;
    for (int e = 1; e <= 10; e++) begin
      tick();
      total++; if (new_o !== 1'b0) begin bad++; $display("FAIL idle_new e=%0d got %b want 0", e, new_o); end
      total++; if (count_o !== '0) begin bad++; $display("FAIL idle_count e=%0d got %0d want 0", e, count_o); end
      total++; if (out_o !== '0)   begin bad++; $display("FAIL idle_out e=%0d got %h want 0", e, out_o); end
    end
  endtask

  task automatic test_single();
    do_reset();
    result_i = 32'h11;
    for (int e = 1; e <= 12; e++) begin
      tick();
      total++;
      if (new_o !== (e == 1)) begin bad++; $display("FAIL single_new e=%0d got %b want %b", e, new_o, (e == 1)); end
      total++;
      if (count_o !== ((e == 1) ? 3'd0 : 3'd1)) begin bad++; $display("FAIL single_count e=%0d got %0d", e, count_o); end
      total++;
      if (out_o !== ((e == 1) ? 32'h0 : 32'h11)) begin bad++; $display("FAIL single_out e=%0d got %h", e, out_o); end
      total++;
      if (out_idx_o !== 2'd0) begin bad++; $display("FAIL single_idx e=%0d got %0d want 0", e, out_idx_o); end
    end
  endtask

  task automatic test_rotate();
    logic [DATA_W-1:0] v;
    logic [1:0] ix;
    do_reset();
    exp_v.delete(); exp_i.delete();
`ifdef OUTREAD_JUMP_NEW_EN
    push_run(32'h11, 0, 2); push_run(32'h22, 1, 2); push_run(32'h33, 2, 4);
    push_run(32'h11, 0, 4); push_run(32'h22, 1, 4); push_run(32'h33, 2, 4);
`else
    push_run(32'h11, 0, 4); push_run(32'h22, 1, 4); push_run(32'h33, 2, 4);
    push_run(32'h11, 0, 4); push_run(32'h22, 1, 4);
`endif
    for (int e = 1; e <= 21; e++) begin
      if (e == 1) result_i = 32'h11;
      else if (e == 3) result_i = 32'h22;
      else if (e == 5) result_i = 32'h33;
      tick();
      if (e >= 2 && exp_v.size() > 0) begin
        v = exp_v.pop_front(); ix = exp_i.pop_front();
        total++; if (out_o !== v)      begin bad++; $display("FAIL rot_out e=%0d got %h want %h", e, out_o, v); end
        total++; if (out_idx_o !== ix) begin bad++; $display("FAIL rot_idx e=%0d got %0d want %0d", e, out_idx_o, ix); end
      end
    end
  endtask

  task automatic test_saturate();
    logic [DATA_W-1:0] v;
    logic [1:0] ix;
    int start;
    do_reset();
    exp_v.delete(); exp_i.delete();
`ifdef OUTREAD_JUMP_NEW_EN
    start = 11;
    push_run(32'hA3, 0, 4); push_run(32'hA4, 1, 4); push_run(32'hA5, 2, 4);
    push_run(32'hA6, 3, 4); push_run(32'hA3, 0, 4);
`else
    start = 10;
    push_run(32'hA5, 2, 4); push_run(32'hA6, 3, 4); push_run(32'hA3, 0, 4);
    push_run(32'hA4, 1, 4); push_run(32'hA5, 2, 4);
`endif
    for (int e = 1; e <= 30; e++) begin
      if (e <= 6) result_i = 32'hA0 + 32'(e);
      tick();
      if (e <= 7) begin
        total++;
        if (new_o !== (e <= 6)) begin bad++; $display("FAIL sat_new e=%0d got %b want %b", e, new_o, (e <= 6)); end
      end
      if (e >= 2) begin
        total++;
        if (count_o !== ((e - 1 > 4) ? 3'd4 : 3'(e - 1))) begin bad++; $display("FAIL sat_count e=%0d got %0d", e, count_o); end
      end
      if (e >= start && exp_v.size() > 0) begin
        v = exp_v.pop_front(); ix = exp_i.pop_front();
        total++; if (out_o !== v)      begin bad++; $display("FAIL sat_out e=%0d got %h want %h", e, out_o, v); end
        total++; if (out_idx_o !== ix) begin bad++; $display("FAIL sat_idx e=%0d got %0d want %0d", e, out_idx_o, ix); end
      end
    end
  endtask

  task automatic test_hold();
    logic [DATA_W-1:0] v;
    logic [1:0] ix;
    do_reset();
    exp_v.delete(); exp_i.delete();
`ifdef OUTREAD_JUMP_NEW_EN
    push_run(32'h22, 1, 10); push_run(32'h11, 0, 1);
`else
    push_run(32'h22, 1, 12); push_run(32'h11, 0, 1);
`endif
    for (int e = 1; e <= 20; e++) begin
      if (e == 1) result_i = 32'h11;
      else if (e == 3) result_i = 32'h22;
      hold_i = (e >= 7 && e <= 16);
      tick();
      if (e >= 8 && exp_v.size() > 0) begin
        v = exp_v.pop_front(); ix = exp_i.pop_front();
        total++; if (out_o !== v)      begin bad++; $display("FAIL hold_out e=%0d got %h want %h", e, out_o, v); end
        total++; if (out_idx_o !== ix) begin bad++; $display("FAIL hold_idx e=%0d got %0d want %0d", e, out_idx_o, ix); end
      end
    end
    hold_i = 1'b0;
  endtask

  task automatic test_clear();
    do_reset();
    for (int e = 1; e <= 6; e++) begin
      if (e == 1) result_i = 32'h11;
      else if (e == 3) result_i = 32'h22;
      tick();
    end
    // bus change coincident with clear must not be pushed, nor re-pushed later
    clear_i = 1'b1; result_i = 32'h55;
    tick();
    clear_i = 1'b0;
    total++; if (out_o !== '0)     begin bad++; $display("FAIL clr_out got %h want 0", out_o); end
    total++; if (count_o !== '0)   begin bad++; $display("FAIL clr_count got %0d want 0", count_o); end
    total++; if (out_idx_o !== '0) begin bad++; $display("FAIL clr_idx got %0d want 0", out_idx_o); end
    total++; if (new_o !== 1'b0)   begin bad++; $display("FAIL clr_new got %b want 0", new_o); end
    for (int e = 8; e <= 9; e++) begin
      tick();
      total++; if (new_o !== 1'b0) begin bad++; $display("FAIL clr_hold_new e=%0d got %b want 0", e, new_o); end
      total++; if (count_o !== '0) begin bad++; $display("FAIL clr_hold_count e=%0d got %0d want 0", e, count_o); end
      total++; if (out_o !== '0)   begin bad++; $display("FAIL clr_hold_out e=%0d got %h want 0", e, out_o); end
    end
    result_i = 32'h66;
    tick();
    total++; if (new_o !== 1'b1) begin bad++; $display("FAIL clr_repush_new got %b want 1", new_o); end
    tick();
    total++; if (count_o !== 3'd1)  begin bad++; $display("FAIL clr_repush_count got %0d want 1", count_o); end
    total++; if (out_o !== 32'h66)  begin bad++; $display("FAIL clr_repush_out got %h want 66", out_o); end
    total++; if (new_o !== 1'b0)    begin bad++; $display("FAIL clr_repush_new2 got %b want 0", new_o); end
  endtask

  task automatic test_mid_reset();
    do_reset();
    for (int e = 1; e <= 8; e++) begin
      if (e == 1) result_i = 32'h11;
      else if (e == 3) result_i = 32'h22;
      else if (e == 5) result_i = 32'h33;
      tick();
    end
    rst = 1'b0;
    tick();
    rst = 1'b1;
    total++; if (out_o !== '0)   begin bad++; $display("FAIL mrst_out got %h want 0", out_o); end
    total++; if (count_o !== '0) begin bad++; $display("FAIL mrst_count got %0d want 0", count_o); end
    total++; if (new_o !== 1'b0) begin bad++; $display("FAIL mrst_new got %b want 0", new_o); end
    // prev_q is back to zero, so the held 0x33 is pushed once into an empty history
    tick();
    total++; if (new_o !== 1'b1) begin bad++; $display("FAIL mrst_push got %b want 1", new_o); end
    tick();
    total++; if (count_o !== 3'd1) begin bad++; $display("FAIL mrst_count2 got %0d want 1", count_o); end
    total++; if (out_o !== 32'h33) begin bad++; $display("FAIL mrst_out2 got %h want 33", out_o); end
  endtask

`ifdef OUTREAD_JUMP_NEW_EN
  task automatic test_jump();
    logic [DATA_W-1:0] v;
    logic [1:0] ix;
    do_reset();
    exp_v.delete(); exp_i.delete();
    push_run(32'h11, 0, 2); push_run(32'h33, 2, 4); push_run(32'h11, 0, 1);
    for (int e = 1; e <= 14; e++) begin
      if (e == 1) result_i = 32'h11;
      else if (e == 3) result_i = 32'h22;
      else if (e == 9) result_i = 32'h33;
      tick();
      if (e >= 8 && exp_v.size() > 0) begin
        v = exp_v.pop_front(); ix = exp_i.pop_front();
        total++; if (out_o !== v)      begin bad++; $display("FAIL jump_out e=%0d got %h want %h", e, out_o, v); end
        total++; if (out_idx_o !== ix) begin bad++; $display("FAIL jump_idx e=%0d got %0d want %0d", e, out_idx_o, ix); end
      end
    end
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_rotate();
    test_saturate();
    test_hold();
    test_clear();
    test_mid_reset();
`ifdef OUTREAD_JUMP_NEW_EN
    test_jump();
`endif
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
